// File: rtl/adc_serial_emulator.sv
// Fabric stand-in for an ADCXX1S101 serial ADC: takes pixel samples from a loader and
// shifts each one out as a cs_n/sclk framed word, MSB first, changing sdata on sclk falls.
//
//   state   | meaning
//   IDLE    | output released, waiting for cs_n to fall
//   SHIFT   | driving the frame, counting sclk rising edges
//   WAIT_CS | frame delivered, driving 0 until cs_n rises
module adc_serial_emulator #(
    parameter int DATA_BITS   = 8,
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_ZEROS  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 cs_n,
    input  logic                 sclk,
    output logic                 sdata,
    output logic                 sdata_oe,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 underrun
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TAIL  = FRAME_BITS - LEAD_ZEROS - DATA_BITS;

    if (LEAD_ZEROS + DATA_BITS > FRAME_BITS || SYNC_STAGES < 1) begin : g_param_check
        $error("adc_serial_emulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
    logic                   cs_prev, sck_prev;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    logic [DATA_BITS-1:0]   hold, hold_nx, last, last_nx;
    logic                   hold_full, hold_full_nx;
    logic [FRAME_BITS-1:0]  shift_reg, shift_nx;
    logic [CNT_W-1:0]       rise_cnt, rise_cnt_nx;
    logic                   sdata_nx, sdata_oe_nx;
    logic                   frame_done_nx, frame_abort_nx, underrun_nx;

    logic [DATA_BITS-1:0]   value;
    logic [FRAME_BITS-1:0]  load_word, shifted;
    logic                   accept, done_now;

    // Idle levels (cs_n high, sclk high) so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b1;
        end else begin
            cs_sync  <= (cs_sync << 1) | SYNC_STAGES'(cs_n);
            sck_sync <= (sck_sync << 1) | SYNC_STAGES'(sclk);
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign cs_fall  =  cs_prev  & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise  = ~cs_prev  &  cs_sync[SYNC_STAGES-1];
    assign sck_rise = ~sck_prev &  sck_sync[SYNC_STAGES-1];
    assign sck_fall =  sck_prev & ~sck_sync[SYNC_STAGES-1];

    assign sample_ready = ~hold_full;
    assign accept       = sample_valid & ~hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= '0;
            hold_full   <= 1'b0;
            last        <= '0;
            shift_reg   <= '0;
            rise_cnt    <= '0;
            sdata       <= 1'b0;
            sdata_oe    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            hold        <= hold_nx;
            hold_full   <= hold_full_nx;
            last        <= last_nx;
            shift_reg   <= shift_nx;
            rise_cnt    <= rise_cnt_nx;
            sdata       <= sdata_nx;
            sdata_oe    <= sdata_oe_nx;
            frame_done  <= frame_done_nx;
            frame_abort <= frame_abort_nx;
            underrun    <= underrun_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        hold_nx        = hold;
        hold_full_nx   = hold_full;
        last_nx        = last;
        shift_nx       = shift_reg;
        rise_cnt_nx    = rise_cnt;
        sdata_nx       = sdata;
        sdata_oe_nx    = sdata_oe;
        frame_done_nx  = 1'b0;
        frame_abort_nx = 1'b0;
        underrun_nx    = 1'b0;
        value          = hold_full ? hold : last;
        load_word      = FRAME_BITS'(value) << TAIL;
        shifted        = shift_reg << 1;
        done_now       = sck_rise && (rise_cnt == CNT_W'(FRAME_BITS - 1));

        // A sample accepted while an underrun frame loads lands in the now-free holder.
        if (accept) begin
            hold_nx      = sample_data;
            hold_full_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    underrun_nx = ~hold_full;
                    last_nx     = value;
                    if (hold_full) hold_full_nx = 1'b0;
                    shift_nx    = load_word;
                    sdata_nx    = load_word[FRAME_BITS-1];
                    sdata_oe_nx = 1'b1;
                    rise_cnt_nx = '0;
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise) rise_cnt_nx = rise_cnt + 1'b1;
                if (cs_rise) begin
                    frame_done_nx  = done_now;
                    frame_abort_nx = ~done_now;
                    sdata_nx       = 1'b0;
                    sdata_oe_nx    = 1'b0;
                    state_nx       = IDLE;
                end else if (done_now) begin
                    frame_done_nx = 1'b1;
                    sdata_nx      = 1'b0;
                    state_nx      = WAIT_CS;
                end else if (sck_fall && rise_cnt != '0 && rise_cnt < CNT_W'(FRAME_BITS)) begin
                    shift_nx = shifted;
                    sdata_nx = shifted[FRAME_BITS-1];
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    sdata_nx    = 1'b0;
                    sdata_oe_nx = 1'b0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc_serial_emulator.sv
// Bench for adc_serial_emulator: a behavioural controller drives cs_n/sclk frames and
// collects bits; a scoreboard of expected frames is checked by an independent monitor.
module tb_adc_serial_emulator;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       cs_n, sclk;
    logic       sdata, sdata_oe;
    logic       frame_done, frame_abort, underrun;

    always #5 clk = ~clk;

    adc_serial_emulator #(
        .DATA_BITS(8), .FRAME_BITS(16), .LEAD_ZEROS(3), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .cs_n(cs_n), .sclk(sclk), .sdata(sdata), .sdata_oe(sdata_oe),
        .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
    );

    typedef struct {
        bit        is_abort;
        bit [15:0] word;
        int        nbits;
        bit        urun;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] model_last = 8'h00;
    int         errors = 0;
    int         checks = 0;
    logic [15:0] rx_word = '0;
    bit         urun_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (underrun) urun_seen = 1'b1;
            if (frame_done || frame_abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_event: done=%0b abort=%0b with nothing expected",
                             frame_done, frame_abort);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_kind_abort", 32'(frame_abort), 32'(e.is_abort));
                    chk("frame_bits", 32'(rx_word), 32'(e.word >> (16 - e.nbits)));
                    chk("frame_underrun", 32'(urun_seen), 32'(e.urun));
                    urun_seen = 1'b0;
                end
            end
        end
    end

    task automatic load(input logic [7:0] d);
        bit done = 1'b0;
        @(negedge clk);
        sample_data  = d;
        sample_valid = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (sample_ready) begin
                pend_q.push_back(d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: sample 0x%0h never accepted", d);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_sdata", 32'(sdata), 0);
        chk("rst_sdata_oe", 32'(sdata_oe), 0);
        chk("rst_sample_ready", 32'(sample_ready), 1);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_abort", 32'(frame_abort), 0);
        chk("rst_underrun", 32'(underrun), 0);
    endtask

    // Controller model: n_rises < 16 aborts; reset_at > 0 asserts reset after that rising edge.
    task automatic run_frame(input int n_rises, input int hp, input int reset_at);
        logic [7:0] v;
        bit         u;
        exp_t       e;
        if (pend_q.size() > 0) begin
            v = pend_q.pop_front();
            u = 1'b0;
        end else begin
            v = model_last;
            u = 1'b1;
        end
        model_last = v;
        e.is_abort = (n_rises < 16);
        e.word     = {3'b000, v, 5'b00000};
        e.nbits    = n_rises;
        e.urun     = u;
        exp_q.push_back(e);

        @(negedge clk);
        rx_word = '0;
        cs_n    = 1'b0;
        repeat (hp) @(negedge clk);
        for (int i = 0; i < n_rises; i++) begin
            sclk = 1'b0;
            repeat (hp) @(negedge clk);
            sclk    = 1'b1;
            rx_word = {rx_word[14:0], sdata};
            if (i == reset_at - 1) begin
                reset = 1'b1;
                cs_n  = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                void'(exp_q.pop_back());
                pend_q.delete();
                model_last = 8'h00;
                urun_seen  = 1'b0;
                check_reset_outputs();
                repeat (hp) @(negedge clk);
                return;
            end
            repeat (hp) @(negedge clk);
        end
        cs_n = 1'b1;
        for (int k = 0; k < SYNC + 2; k++) begin
            @(negedge clk);
            if (!sdata_oe) break;
        end
        chk("oe_release", 32'(sdata_oe), 0);
        repeat (hp) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        cs_n         = 1'b1;
        sclk         = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs();

        load(8'hA5);
        chk("ready_after_load", 32'(sample_ready), 0);
        run_frame(16, 4, 0);
        run_frame(16, 4, 0);
        chk("ready_after_underrun", 32'(sample_ready), 1);

        load(8'h3C);
        run_frame(6, 4, 0);
        run_frame(16, 4, 0);

        load(8'h11);
        fork
            load(8'h22);
            begin
                repeat (3) @(negedge clk);
                chk("ready_stall", 32'(sample_ready), 0);
                run_frame(16, 4, 0);
            end
        join
        chk("ready_second_held", 32'(sample_ready), 32'(pend_q.size() == 0));
        run_frame(16, 4, 0);
        chk("ready_drained", 32'(sample_ready), 1);

        load(8'h5A);
        run_frame(16, 4, 9);
        run_frame(16, 4, 0);

        for (int n = 0; n < 12; n++) begin
            int nr;
            if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame(nr, int'($urandom_range(4, 6)), 0);
            chk("ready_random", 32'(sample_ready), 32'(pend_q.size() == 0));
        end

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
